// File: rtl/max_req_sched_if.sv
// Bundle of the requester, max-stage and response signals of max_req_sched.
// The slave modport is the scheduler's view. The master modport is the view
// of the surrounding requesters, max stage and response consumer.
interface max_req_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_a;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          max_rdy;
  logic [DATA_WIDTH-1:0]         max_a;
  logic [DATA_WIDTH-1:0]         max_b;
  logic [DATA_WIDTH-1:0]         max_result;
  logic                          rsp_valid;
  logic [ID_W-1:0]               rsp_id;
  logic [DATA_WIDTH-1:0]         rsp_data;
  logic                          rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, max_result, rsp_ready,
    output req_ready, max_rdy, max_a, max_b, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, max_result, rsp_ready,
    input  req_ready, max_rdy, max_a, max_b, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/max_req_sched.sv
// Round-robin scheduler that shares one registered max stage among NUM_REQ
// requesters. One operation is in flight at a time:
// IDLE (arbitrate/accept) -> ISSUE (max_rdy pulse) -> WAIT (result valid)
// -> RESP (hold the tagged response until the consumer takes it).
module max_req_sched #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  max_req_sched_if.slave        bus,
  output logic                  busy
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_tag;
  logic                  r_max_rdy;
  logic [DATA_WIDTH-1:0] r_max_a;
  logic [DATA_WIDTH-1:0] r_max_b;
  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;

  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic [ID_W-1:0]       w_idx;
  logic                  w_accept;

  // Round-robin search: first set req_valid at ptr, ptr+1, ... (wraps mod NUM_REQ).
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = r_ptr + ID_W'(k);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  // One-hot grant, only in IDLE and never while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if (w_accept && rst_n) begin
      bus.req_ready = NUM_REQ'(1) << w_win;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its pre-edge inputs regardless of statement order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Operand issue, tag/pointer bookkeeping and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_tag       <= '0;
      r_max_rdy   <= 1'b0;
      r_max_a     <= '0;
      r_max_b     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_max_a   <= bus.req_a[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_max_b   <= bus.req_b[w_win*DATA_WIDTH +: DATA_WIDTH];
            r_max_rdy <= 1'b1;
            r_tag     <= w_win;
            r_ptr     <= w_win + 1'b1;
          end
        end
        S_ISSUE: begin
          r_max_rdy <= 1'b0;
        end
        S_WAIT: begin
          r_rsp_data  <= bus.max_result;
          r_rsp_id    <= r_tag;
          r_rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.max_rdy   = r_max_rdy;
  assign bus.max_a     = r_max_a;
  assign bus.max_b     = r_max_b;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_max_req_sched.sv
// Directed bench for max_req_sched: reset, round-robin fairness, a table of
// single operations, response backpressure and reset during ISSUE.
module tb_max_req_sched;
  localparam int DW = 8;
  localparam int NR = 4;

  logic clk;
  logic rst_n;
  logic busy;

  int n_tests = 0;
  int n_fail  = 0;

  max_req_sched_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) sif ();

  max_req_sched #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sif),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered max stage: larger operand, or 0 when the operands are equal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sif.max_result <= '0;
    end else if (sif.max_rdy) begin
      sif.max_result <= (sif.max_a == sif.max_b) ? '0 :
                        ((sif.max_a > sif.max_b) ? sif.max_a : sif.max_b);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    sif.req_valid = '0;
    sif.req_a     = '0;
    sif.req_b     = '0;
  endtask

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    sif.req_valid[id]        = 1'b1;
    sif.req_a[id*DW +: DW]   = a;
    sif.req_b[id*DW +: DW]   = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(sif.req_ready), 32'h0);
    check({tag, "_max_rdy"},   32'(sif.max_rdy),   32'h0);
    check({tag, "_max_a"},     32'(sif.max_a),     32'h0);
    check({tag, "_max_b"},     32'(sif.max_b),     32'h0);
    check({tag, "_rsp_valid"}, 32'(sif.rsp_valid), 32'h0);
    check({tag, "_rsp_id"},    32'(sif.rsp_id),    32'h0);
    check({tag, "_rsp_data"},  32'(sif.rsp_data),  32'h0);
    check({tag, "_busy"},      32'(busy),          32'h0);
  endtask

  // One complete operation from a single requester with rsp_ready high.
  task automatic do_op(input int id, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d);
    clear_reqs();
    sif.rsp_ready = 1'b1;
    set_req(id, a, b);
    #1;
    check("op_req_ready", 32'(sif.req_ready), 32'd1 << id);
    check("op_idle_busy", 32'(busy), 32'h0);
    tick();                       // accept edge n
    clear_reqs();
    #1;
    check("op_max_rdy_hi", 32'(sif.max_rdy), 32'h1);
    check("op_max_a", 32'(sif.max_a), 32'(a));
    check("op_max_b", 32'(sif.max_b), 32'(b));
    check("op_ready_busy", 32'(sif.req_ready), 32'h0);
    tick();                       // edge n+1
    check("op_max_rdy_lo", 32'(sif.max_rdy), 32'h0);
    check("op_max_a_hold", 32'(sif.max_a), 32'(a));
    check("op_no_rsp_yet", 32'(sif.rsp_valid), 32'h0);
    tick();                       // edge n+2
    check("op_rsp_valid", 32'(sif.rsp_valid), 32'h1);
    check("op_rsp_id", 32'(sif.rsp_id), 32'(id));
    check("op_rsp_data", 32'(sif.rsp_data), 32'(exp_d));
    tick();                       // edge n+3 handshake
    check("op_rsp_done", 32'(sif.rsp_valid), 32'h0);
    check("op_back_idle", 32'(busy), 32'h0);
  endtask

  logic [7:0] fa [4];
  logic [7:0] fb [4];
  logic [7:0] fe [4];

  initial begin
    vecs[0] = '{id: 0, a: 8'h25, b: 8'h7F, exp_d: 8'h7F};
    vecs[1] = '{id: 2, a: 8'h40, b: 8'h40, exp_d: 8'h00};
    vecs[2] = '{id: 3, a: 8'hFF, b: 8'h00, exp_d: 8'hFF};
    vecs[3] = '{id: 1, a: 8'h80, b: 8'h7F, exp_d: 8'h80};
    vecs[4] = '{id: 0, a: 8'h01, b: 8'h02, exp_d: 8'h02};

    fa = '{8'h11, 8'h22, 8'h33, 8'h44};
    fb = '{8'h05, 8'h60, 8'h33, 8'h80};
    fe = '{8'h11, 8'h60, 8'h00, 8'h80};

    // Reset with every requester asking.
    rst_n = 1'b0;
    sif.rsp_ready = 1'b1;
    clear_reqs();
    for (int i = 0; i < NR; i++) set_req(i, fa[i], fb[i]);
    #1;
    check_all_zero("rst");
    tick();
    tick();
    check_all_zero("rst_hold");
    rst_n = 1'b1;
    #1;

    // Fairness: grants 0,1,2,3,0, four cycles apart.
    for (int g = 0; g < 5; g++) begin
      check("fair_grant", 32'(sif.req_ready), 32'd1 << (g % 4));
      tick();
      check("fair_max_rdy", 32'(sif.max_rdy), 32'h1);
      check("fair_max_a", 32'(sif.max_a), 32'(fa[g % 4]));
      tick();
      tick();
      check("fair_rsp_valid", 32'(sif.rsp_valid), 32'h1);
      check("fair_rsp_id", 32'(sif.rsp_id), 32'(g % 4));
      check("fair_rsp_data", 32'(sif.rsp_data), 32'(fe[g % 4]));
      tick();
    end
    clear_reqs();
    #1;
    check("fair_drop_no_grant", 32'(sif.req_ready), 32'h0);
    tick();
    check("fair_drop_idle", 32'(busy), 32'h0);

    // Table of single-requester operations.
    for (int v = 0; v < 5; v++) begin
      do_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].exp_d);
    end

    // Backpressure: response held for 5 cycles, competing request waits.
    clear_reqs();
    sif.rsp_ready = 1'b0;
    set_req(1, 8'h9A, 8'h3C);
    #1;
    check("bp_grant1", 32'(sif.req_ready), 32'h2);
    tick();
    clear_reqs();
    set_req(3, 8'h5E, 8'hE5);
    #1;
    check("bp_no_grant_issue", 32'(sif.req_ready), 32'h0);
    tick();
    tick();
    check("bp_rsp_valid", 32'(sif.rsp_valid), 32'h1);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_hold_valid", 32'(sif.rsp_valid), 32'h1);
      check("bp_hold_id", 32'(sif.rsp_id), 32'h1);
      check("bp_hold_data", 32'(sif.rsp_data), 32'h9A);
      check("bp_hold_ready", 32'(sif.req_ready), 32'h0);
      check("bp_hold_max_rdy", 32'(sif.max_rdy), 32'h0);
    end
    sif.rsp_ready = 1'b1;
    tick();                       // handshake edge
    check("bp_rsp_cleared", 32'(sif.rsp_valid), 32'h0);
    check("bp_grant3", 32'(sif.req_ready), 32'h8);
    tick();                       // next accept one cycle later
    clear_reqs();
    check("bp_next_max_rdy", 32'(sif.max_rdy), 32'h1);
    check("bp_next_max_a", 32'(sif.max_a), 32'h5E);
    check("bp_next_max_b", 32'(sif.max_b), 32'hE5);
    tick();
    tick();
    check("bp_next_rsp_id", 32'(sif.rsp_id), 32'h3);
    check("bp_next_rsp_data", 32'(sif.rsp_data), 32'hE5);
    tick();

    // Reset while in ISSUE: operation dropped, pointer back to 0.
    clear_reqs();
    set_req(2, 8'h10, 8'h20);
    #1;
    check("ri_grant2", 32'(sif.req_ready), 32'h4);
    tick();
    clear_reqs();
    #1;
    check("ri_max_rdy", 32'(sif.max_rdy), 32'h1);
    rst_n = 1'b0;
    #1;
    check_all_zero("ri");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("ri_no_rsp", 32'(sif.rsp_valid), 32'h0);
      check("ri_idle", 32'(busy), 32'h0);
    end
    for (int i = 0; i < NR; i++) set_req(i, fa[i], fb[i]);
    #1;
    check("ri_ptr_zero", 32'(sif.req_ready), 32'h1);
    clear_reqs();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/max_req_sched.md
# max_req_sched

Round-robin scheduler that shares one registered max stage among NUM_REQ requesters. It accepts one operand pair at a time, drives the stage's `max_rdy`/`A`/`B` inputs, and captures the stage result one cycle later. It returns that result on a tagged valid/ready response channel. It sits between the requester blocks and the single max-stage instance.

## Interface
- `DATA_WIDTH`, 8: operand and result width.
- `NUM_REQ`, 4: number of requesters; a power of two in 2..8.
- `ID_W`, $clog2(NUM_REQ): width of `rsp_id`. Derived; do not override.

- `clk`  in  1  rising-edge clock for all state.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_a`  in  NUM_REQ*DATA_WIDTH  flattened operands; requester i uses `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_b`  in  NUM_REQ*DATA_WIDTH  flattened operands, same slicing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot accept, combinational.
- `max_rdy`  out  1  enable to the max stage; registered.
- `max_a`  out  DATA_WIDTH  operand A to the max stage; registered.
- `max_b`  out  DATA_WIDTH  operand B to the max stage; registered.
- `max_result`  in  DATA_WIDTH  max-stage output register.
- `rsp_valid`  out  1  response valid.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_data`  out  DATA_WIDTH  result returned to the requester.
- `rsp_ready`  in  1  response consumer ready.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Exactly one operation is outstanding at a time.
- IDLE:
  - The arbiter searches `ptr`, `ptr+1`, ... (mod NUM_REQ) for the first set `req_valid` bit. That requester is the winner i.
  - `req_ready[i]`=1; all other `req_ready` bits are 0.
  - On that edge: `max_a`<=A_i, `max_b`<=B_i, `max_rdy`<=1, `tag`<=i, `ptr`<=(i+1) mod NUM_REQ, next state ISSUE.
  - If no `req_valid` bit is set, nothing changes.
- ISSUE: `max_rdy`=1 for exactly this one cycle; the max stage samples at the end of the cycle. Next edge: `max_rdy`<=0, next state WAIT. `max_a` and `max_b` hold their values.
- WAIT: `max_result` is valid. Next edge: `rsp_data`<=`max_result`, `rsp_id`<=`tag`, `rsp_valid`<=1, next state RESP.
- RESP: `rsp_valid`, `rsp_id` and `rsp_data` are held stable until `rsp_valid && rsp_ready`. On that edge: `rsp_valid`<=0, next state IDLE.
- `req_ready` is all zeros outside IDLE and while `rst_n`=0.
- Result values pass through uninterpreted. The stage returns the larger operand, or 0 when A==B; the scheduler does not reinterpret either case.
- Requesters hold `req_valid`, `req_a` and `req_b` until accepted. Dropping `req_valid` before acceptance is legal and is not an error.
- `ptr` advances only on an accept.

## Timing
- Reset values: state IDLE, `ptr` 0, `tag` 0, `max_rdy` 0, `max_a` 0, `max_b` 0, `rsp_valid` 0, `rsp_id` 0, `rsp_data` 0, `busy` 0.
- Reset asserted mid-operation, in any state: all outputs clear immediately (asynchronously). The pending operation is dropped and no response is ever produced for it.
- Latency: accept at edge n; `max_rdy`=1 between edges n and n+1; `rsp_valid` rises at edge n+2.
- If `rsp_ready` is already high in RESP, the handshake completes at edge n+3 and the next accept can occur no earlier than edge n+4. Peak throughput is 1 operation per 4 cycles.
- Backpressure: the FSM stays in RESP indefinitely; `max_rdy` stays 0 and no new requests are accepted.
- A request whose `req_valid` rises in the same cycle the FSM returns to IDLE is arbitrated in that IDLE cycle.

## Test plan
- Reset: hold `rst_n`=0 with all `req_valid` high -> every output is 0, including `req_ready`. After release, the first grant goes to requester 0.
- Single request: req0 A=0x25, B=0x7F, `rsp_ready`=1 ->
  - `req_ready`=4'b0001 in the accept cycle.
  - `max_rdy` is high for exactly one cycle, with `max_a`=0x25 and `max_b`=0x7F.
  - `rsp_valid` rises 2 edges after accept, with `rsp_id`=0 and `rsp_data`=0x7F.
- Fairness: all four `req_valid` held high, `rsp_ready`=1 -> grants go in order 0,1,2,3,0, spaced 4 cycles apart. Each `rsp_id` matches its grant.
- Equal operands: req2 only, A=B=0x40 -> `rsp_id`=2, `rsp_data`=0x00.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP ->
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable; `req_ready`=0 and `max_rdy`=0 throughout.
  - After the handshake, the next grant lands one cycle later.
- Reset in ISSUE: drop `rst_n` while `max_rdy`=1 -> all outputs go to 0 before the next edge. After release there is no `rsp_valid` and `ptr` is 0.
